// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: operation select codes and FSM states.
package mdu_pkg;

  localparam logic [3:0] mduMult  = 4'h1;
  localparam logic [3:0] mduMultu = 4'h2;
  localparam logic [3:0] mduDiv   = 4'h3;
  localparam logic [3:0] mduDivu  = 4'h4;
  localparam logic [3:0] mduMthi  = 4'h5;
  localparam logic [3:0] mduMtlo  = 4'h6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MULT_RUN = 2'd1,
    DIV_RUN  = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu_divider.sv
// Combinational 32-bit divider: signed or unsigned quotient/remainder with div-by-zero flag.
module mdu_divider (
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] quo,
  output logic [31:0] rem,
  output logic        div_zero
);

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag;

  assign a_neg    = is_signed & a[31];
  assign b_neg    = is_signed & b[31];
  assign a_mag    = a_neg ? (~a + 32'd1) : a;
  assign b_mag    = b_neg ? (~b + 32'd1) : b;
  assign div_zero = (b == 32'd0);

  // Magnitude divide then sign fixup; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign q_mag = div_zero ? 32'd0 : (a_mag / b_mag);
  assign r_mag = div_zero ? 32'd0 : (a_mag % b_mag);
  assign quo   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem   = a_neg ? (~r_mag + 32'd1) : r_mag;

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO; result commits after a fixed Busy window.
//   state    | meaning
//   IDLE     | accepts Start; mthi/mtlo write HI/LO directly
//   MULT_RUN | product latched, counting down MULT_CYCLES before commit
//   DIV_RUN  | quotient/remainder latched, counting down DIV_CYCLES before commit
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [3:0]  MDUCtrl,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  mdu_state_t  state;
  logic [3:0]  count;
  logic        busy_q;
  logic [31:0] hi_q, lo_q, res_hi, res_lo;
  logic        res_commit;

  logic        mul_signed;
  logic [63:0] ext_a, ext_b, product;
  logic [31:0] quo, rem;
  logic        div_zero;

  // Low 64 bits of the sign/zero-extended product give both mult and multu.
  assign mul_signed = (MDUCtrl == mduMult);
  assign ext_a      = {{32{mul_signed & SrcA[31]}}, SrcA};
  assign ext_b      = {{32{mul_signed & SrcB[31]}}, SrcB};
  assign product    = ext_a * ext_b;

  mdu_divider u_div (
    .is_signed (MDUCtrl == mduDiv),
    .a         (SrcA),
    .b         (SrcB),
    .quo       (quo),
    .rem       (rem),
    .div_zero  (div_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      busy_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      res_hi     <= '0;
      res_lo     <= '0;
      res_commit <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            case (MDUCtrl)
              mduMult, mduMultu: begin
                {res_hi, res_lo} <= product;
                res_commit       <= 1'b1;
                count            <= MULT_CNT;
                state            <= MULT_RUN;
                busy_q           <= 1'b1;
              end
              mduDiv, mduDivu: begin
                res_hi     <= rem;
                res_lo     <= quo;
                res_commit <= ~div_zero;
                count      <= DIV_CNT;
                state      <= DIV_RUN;
                busy_q     <= 1'b1;
              end
              mduMthi: hi_q <= SrcA;
              mduMtlo: lo_q <= SrcA;
              default: ;
            endcase
          end
        end
        MULT_RUN, DIV_RUN: begin
          if (count == 4'd1) begin
            if (res_commit) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
            count  <= '0;
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            count <= count - 4'd1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          count  <= '0;
        end
      endcase
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
